// File: rtl/rr_arbiter_pkg.sv
// Shared constants, state type and pointer helper for the 8-way round-robin arbiter.
package rr_arbiter_pkg;
    localparam int NREQ = 8;
    localparam int IDXW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Power-of-two width makes the mod-8 wrap free.
    function automatic logic [IDXW-1:0] next_ptr(input logic [IDXW-1:0] idx);
        return idx + 1'b1;
    endfunction
endpackage

// File: rtl/prio_enc8.sv
// Combinational round-robin priority encoder: first set bit of (req & mask)
// searching upward from ptr with wrap.
module prio_enc8
    import rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    input  logic [NREQ-1:0] mask,
    output logic            found,
    output logic [IDXW-1:0] idx
);
    logic [NREQ-1:0] w_req;
    logic [IDXW-1:0] w_j;

    assign w_req = req & mask;

    // Walk from the far end back to ptr so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_j   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = ptr + IDXW'(k);
            if (w_req[w_j]) begin
                found = 1'b1;
                idx   = w_j;
            end
        end
    end
endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with registered one-hot/binary grant and
// optional forced release after MAX_HOLD cycles.
module rr_arbiter8
    import rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);
    localparam logic [7:0] LIM = 8'(MAX_HOLD);

    state_t          r_state;
    logic [IDXW-1:0] r_ptr;
    logic [7:0]      r_cnt;
    logic [NREQ-1:0] r_gnt;
    logic [IDXW-1:0] r_idx;
    logic            r_vld;
    logic            r_to;

    state_t          w_nxt_state;
    logic [IDXW-1:0] w_nxt_ptr;
    logic [7:0]      w_nxt_cnt;
    logic [NREQ-1:0] w_nxt_gnt;
    logic [IDXW-1:0] w_nxt_idx;
    logic            w_nxt_vld;
    logic            w_nxt_to;

    logic [IDXW-1:0] w_sptr;
    logic [NREQ-1:0] w_own_mask;
    logic            w_nfound;
    logic [IDXW-1:0] w_nidx;
    logic            w_mfound;
    logic [IDXW-1:0] w_midx;
    logic            w_own_req;
    logic            w_limit;

    // While granted, any re-arbitration starts just past the owner.
    assign w_sptr     = (r_state == GRANT) ? next_ptr(r_idx) : r_ptr;
    assign w_own_mask = ~({{(NREQ-1){1'b0}}, 1'b1} << r_idx);
    assign w_own_req  = req[r_idx];
    assign w_limit    = (MAX_HOLD != 0) && (r_cnt == LIM);

    prio_enc8 u_enc_norm (
        .req   (req),
        .ptr   (w_sptr),
        .mask  ({NREQ{1'b1}}),
        .found (w_nfound),
        .idx   (w_nidx)
    );

    prio_enc8 u_enc_mask (
        .req   (req),
        .ptr   (w_sptr),
        .mask  (w_own_mask),
        .found (w_mfound),
        .idx   (w_midx)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ptr   = r_ptr;
        w_nxt_cnt   = r_cnt;
        w_nxt_gnt   = r_gnt;
        w_nxt_idx   = r_idx;
        w_nxt_vld   = r_vld;
        w_nxt_to    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_nfound) begin
                    w_nxt_state = GRANT;
                    w_nxt_gnt   = {{(NREQ-1){1'b0}}, 1'b1} << w_nidx;
                    w_nxt_idx   = w_nidx;
                    w_nxt_vld   = 1'b1;
                    w_nxt_cnt   = 8'd1;
                end
            end
            GRANT: begin
                if (!w_own_req) begin
                    w_nxt_ptr = next_ptr(r_idx);
                    if (w_nfound) begin
                        w_nxt_gnt = {{(NREQ-1){1'b0}}, 1'b1} << w_nidx;
                        w_nxt_idx = w_nidx;
                        w_nxt_cnt = 8'd1;
                    end else begin
                        w_nxt_state = IDLE;
                        w_nxt_gnt   = '0;
                        w_nxt_idx   = '0;
                        w_nxt_vld   = 1'b0;
                        w_nxt_cnt   = 8'd0;
                    end
                end else if (w_limit) begin
                    // With no competitor the owner is simply re-granted.
                    w_nxt_ptr = next_ptr(r_idx);
                    w_nxt_to  = 1'b1;
                    w_nxt_cnt = 8'd1;
                    if (w_mfound) begin
                        w_nxt_gnt = {{(NREQ-1){1'b0}}, 1'b1} << w_midx;
                        w_nxt_idx = w_midx;
                    end
                end else if (r_cnt != 8'hFF) begin
                    w_nxt_cnt = r_cnt + 8'd1;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_vld   <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_ptr   <= w_nxt_ptr;
            r_cnt   <= w_nxt_cnt;
            r_gnt   <= w_nxt_gnt;
            r_idx   <= w_nxt_idx;
            r_vld   <= w_nxt_vld;
            r_to    <= w_nxt_to;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_idx;
    assign gnt_valid = r_vld;
    assign timeout   = r_to;
endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: MAX_HOLD=0 and MAX_HOLD=4 instances share req and are
// compared every cycle against a behavioural model of the arbitration rules.
module tb_rr_arbiter8;
    typedef struct packed {
        int owner;
        int ptr;
        int cnt;
        bit to;
    } m_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;

    logic [7:0] gnt0, gnt4;
    logic [2:0] idx0, idx4;
    logic       v0, v4, to0, to4;

    int n_chk  = 0;
    int n_fail = 0;
    m_t m0, m4;

    always #5 clk = ~clk;

    rr_arbiter8 #(.MAX_HOLD(0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(v0), .timeout(to0)
    );

    rr_arbiter8 #(.MAX_HOLD(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(v4), .timeout(to4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // First requester at or after p (wrapping), skipping excl; -1 if none.
    function automatic int arb(input logic [7:0] r, input int p, input int excl);
        for (int k = 0; k < 8; k++) begin
            int j;
            j = (p + k) % 8;
            if (r[j] && j != excl) return j;
        end
        return -1;
    endfunction

    function automatic m_t mreset();
        m_t m;
        m.owner = -1;
        m.ptr   = 0;
        m.cnt   = 0;
        m.to    = 1'b0;
        return m;
    endfunction

    function automatic m_t mstep(input m_t s, input logic [7:0] r, input int mh);
        m_t n;
        int w;
        n    = s;
        n.to = 1'b0;
        if (s.owner < 0) begin
            w = arb(r, s.ptr, -1);
            if (w >= 0) begin
                n.owner = w;
                n.cnt   = 1;
            end
        end else if (!r[s.owner]) begin
            n.ptr = (s.owner + 1) % 8;
            w = arb(r, n.ptr, -1);
            n.owner = w;
            n.cnt   = (w >= 0) ? 1 : 0;
        end else if (mh != 0 && s.cnt == mh) begin
            n.ptr   = (s.owner + 1) % 8;
            w       = arb(r, n.ptr, s.owner);
            n.to    = 1'b1;
            n.owner = (w >= 0) ? w : s.owner;
            n.cnt   = 1;
        end else begin
            n.cnt = (s.cnt < 255) ? s.cnt + 1 : 255;
        end
        return n;
    endfunction

    task automatic check_model(input string pfx, input m_t m, input logic [7:0] g,
                               input logic [2:0] ix, input logic v, input logic t);
        int eg, ei;
        eg = (m.owner >= 0) ? (1 << m.owner) : 0;
        ei = (m.owner >= 0) ? m.owner : 0;
        chk({pfx, "_gnt"},     32'(g),  eg);
        chk({pfx, "_gnt_idx"}, 32'(ix), ei);
        chk({pfx, "_valid"},   32'(v),  32'(m.owner >= 0));
        chk({pfx, "_timeout"}, 32'(t),  32'(m.to));
    endtask

    task automatic step(input logic [7:0] r);
        @(negedge clk);
        req = r;
        m0 = mstep(m0, r, 0);
        m4 = mstep(m4, r, 4);
        @(posedge clk);
        #1;
        check_model("d0", m0, gnt0, idx0, v0, to0);
        check_model("d4", m4, gnt4, idx4, v4, to4);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = 8'h00;
        rst = 1'b1;
        m0  = mreset();
        m4  = mreset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        m0 = mreset();
        m4 = mreset();
        repeat (2) @(negedge clk);
        chk("rst_gnt0",   32'(gnt0), 32'h0);
        chk("rst_idx0",   32'(idx0), 32'h0);
        chk("rst_valid0", 32'(v0),   32'h0);
        chk("rst_to0",    32'(to0),  32'h0);
        chk("rst_gnt4",   32'(gnt4), 32'h0);
        chk("rst_valid4", 32'(v4),   32'h0);
        rst = 1'b0;

        // single requester, then release to idle
        step(8'h20);
        chk("t1_gnt",   32'(gnt0), 32'h20);
        chk("t1_idx",   32'(idx0), 32'd5);
        chk("t1_valid", 32'(v0),   32'd1);
        step(8'h00);
        chk("t1_idle_gnt",   32'(gnt0), 32'h0);
        chk("t1_idle_valid", 32'(v0),   32'd0);

        // full rotation with one-cycle drops; ptr is 6 after owner 5 released
        do_reset();
        step(8'hFF);
        chk("rot_first", 32'(idx0), 32'd0);
        for (int k = 0; k < 8; k++) begin
            r = 8'hFF & ~(8'h01 << k);
            step(r);
            chk("rot_next", 32'(idx0), 32'((k + 1) % 8));
            chk("rot_nobubble", 32'(v0), 32'd1);
            step(8'hFF);
        end
        step(8'h00);

        // owner 3 drops while 6 and 1 request: 6 then 1
        step(8'h08);
        chk("h3_own", 32'(idx0), 32'd3);
        step(8'h42);
        chk("h3_to6", 32'(idx0), 32'd6);
        step(8'h02);
        chk("h6_to1", 32'(idx0), 32'd1);
        step(8'h00);

        // forced release alternation on MAX_HOLD=4 instance
        do_reset();
        repeat (4) step(8'h81);
        chk("to_hold0", 32'(gnt4), 32'h01);
        chk("to_quiet", 32'(to4),  32'd0);
        step(8'h81);
        chk("to_pulse1", 32'(to4),  32'd1);
        chk("to_gnt7",   32'(gnt4), 32'h80);
        repeat (3) step(8'h81);
        chk("to_hold7", 32'(gnt4), 32'h80);
        step(8'h81);
        chk("to_pulse2", 32'(to4),  32'd1);
        chk("to_gnt0",   32'(gnt4), 32'h01);
        chk("nohold_gnt0", 32'(gnt0), 32'h01);

        // lone requester re-granted with a timeout pulse
        repeat (3) step(8'h01);
        step(8'h01);
        chk("solo_pulse", 32'(to4),  32'd1);
        chk("solo_gnt",   32'(gnt4), 32'h01);
        step(8'h01);
        chk("solo_quiet", 32'(to4), 32'd0);

        // owner drops exactly at the limit: plain hand-off
        step(8'h81);
        step(8'h81);
        step(8'h80);
        chk("sim_noto", 32'(to4),  32'd0);
        chk("sim_gnt",  32'(gnt4), 32'h80);

        // asynchronous reset mid-grant; ptr must restart at 0
        step(8'h04);
        step(8'h08);
        chk("pre_rst_own", 32'(idx0), 32'd3);
        @(negedge clk);
        #2;
        rst = 1'b1;
        req = 8'h00;
        #1;
        chk("arst_gnt0",   32'(gnt0), 32'h0);
        chk("arst_idx0",   32'(idx0), 32'h0);
        chk("arst_valid0", 32'(v0),   32'h0);
        chk("arst_gnt4",   32'(gnt4), 32'h0);
        m0 = mreset();
        m4 = mreset();
        @(negedge clk);
        rst = 1'b0;
        step(8'h0C);
        chk("arst_ptr0", 32'(idx0), 32'd2);
        step(8'h00);

        // random traffic with sticky requests so holds and timeouts occur
        r = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            r = r ^ 8'($urandom & $urandom & $urandom);
            step(r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one resource among eight requesters and reports the winner both as a one-hot grant and as a 3-bit binary index, the same encoding an 8-to-3 encoder produces. It sits in front of any shared datapath slot, such as a bus, a memory port or a mux select. It decides whose turn it is, holds the grant while the owner keeps requesting, and forces a hand-off after a bounded hold time so that no requester starves.

## Interface
Parameters:
- MAX_HOLD, default 16: maximum consecutive cycles one grant may stay valid. 0 disables forced release. Legal range is 0..255.

Ports:
- clk  input  1  rising-edge clock; the block uses one clock only.
- rst  input  1  reset, asynchronous and active-high.
- req  input  8  request vector; bit i high means requester i wants the resource.
- gnt  output  8  one-hot grant; all zeros when idle; registered.
- gnt_idx  output  3  binary index of the granted requester; valid only while gnt_valid is high; registered.
- gnt_valid  output  1  high while any grant is active; equals the OR of gnt.
- timeout  output  1  one-cycle pulse on the clock edge where a grant is forcibly revoked by MAX_HOLD.

## Operation
- Reset values: gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, rotation pointer ptr=0, hold counter cnt=0, state IDLE.
- Arbitration function: pick the first set bit of req, searching upward from ptr and wrapping 7→0. With ptr=0 this is plain lowest-index priority.
- State IDLE:
  - If req≠0, the winner w is chosen.
  - Next edge: gnt=1<<w, gnt_idx=w, gnt_valid=1, cnt=1, state GRANT.
  - If req=0, the block stays in IDLE.
- State GRANT, owner o, three cases evaluated each cycle:
  - Release (req[o]=0): ptr becomes o+1 mod 8, and the block arbitrates in the same cycle over the current req.
    - If another request exists, the new grant appears on the next edge, with no idle bubble.
    - Otherwise all outputs return to reset values except ptr, and state goes to IDLE.
  - Forced release (MAX_HOLD≠0, req[o]=1 and cnt==MAX_HOLD):
    - ptr becomes o+1 mod 8, and the block arbitrates with req[o] masked off.
    - Next edge: timeout=1 and the new grant is loaded.
    - If no other requester exists, o is re-granted with cnt=1, and timeout still pulses.
  - Hold (otherwise): outputs are unchanged and cnt increments. cnt saturates at 255 when MAX_HOLD=0.
- Fairness: after any release, requester o has the lowest priority. Any requester that holds req high is therefore granted within 7 grant tenures.
- Simultaneous events:
  - If the owner drops req in the same cycle the limit is reached, the block treats it as a normal release and timeout stays 0.
  - Requests other than the owner's never preempt a hold.
- Changes to req that are not the owner's have no effect until the next arbitration.
- Reset asserted mid-grant clears the outputs immediately, asynchronously. The first arbitration after reset uses ptr=0.

## Timing
- Latency from a req rise in IDLE to the gnt rise is 1 clock edge.
- Hand-off: when the owner drops req in cycle n, the new owner's gnt is high from edge n+1. The old owner's gnt falls at the same edge.
- A grant is valid for at most MAX_HOLD cycles. timeout coincides with the first cycle of the replacement grant.
- All outputs come from flops; there is no combinational path from req to the outputs.
- Requesters must treat gnt as sampled at the rising edge. Dropping req releases the grant on the following edge.

## Structure
- Package rr_arbiter_pkg holds:
  - constants NREQ=8 and IDXW=3.
  - state enum {IDLE, GRANT}.
  - function next_ptr(idx) returning idx+1 mod 8.
- Sub-module prio_enc8: an 8-bit round-robin priority encoder.
  - Inputs are req[7:0], ptr[2:0] and mask[7:0].
  - Outputs are found and idx[2:0].
  - Purely combinational, and reused for both the normal and the masked search.
- Top level: state register, ptr, cnt, and the output registers.

## Test plan
- Reset then req=8'b0010_0000: on edge 1 after req, gnt=8'h20, gnt_idx=5, gnt_valid=1. Dropping req gives gnt=0 and gnt_valid=0 on the next edge.
- req=8'hFF held, owner drops and re-raises req each tenure, MAX_HOLD=0: grant order is 0,1,2,…,7,0, with no bubble between tenures.
- Owner 3 drops while req[6] and req[1] are high: the next edge grants 6 (gnt_idx=6), followed later by 1.
- MAX_HOLD=4, req=8'h81 held constantly: owner 0 gets 4 cycles, then timeout=1 with gnt=8'h80, then 4 cycles for owner 7, then owner 0 again with a timeout pulse. With only req=8'h01, owner 0 is re-granted and timeout pulses every 4 cycles.
- Owner drop and MAX_HOLD reached in the same cycle: timeout=0 and a normal hand-off occurs.
- Assert rst mid-grant, between clock edges: gnt, gnt_idx and gnt_valid go to 0 immediately. After release with req=8'h0C, the grant goes to 2, showing that ptr was reset.
